// File: rtl/spi_sclk_gen.sv
// SPI master serial-clock generator: frames one DATA_W-bit transfer per start
// and emits registered sclk/cs_n plus single-cycle edge strobes.
module spi_sclk_gen #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cpol,
  input  logic [DIV_W-1:0] clk_div,
  output logic             busy,
  output logic             done,
  output logic             cs_n,
  output logic             sclk,
  output logic             first_edge,
  output logic             leading_edge,
  output logic             trailing_edge
);

  localparam int EDGES = 2 * DATA_W;
  localparam int KW    = $clog2(EDGES + 1);

  typedef enum logic [1:0] {IDLE, START, RUN, HOLD} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [KW-1:0]    k_q, k_d;
  logic             cpol_q, cpol_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             fe_q, fe_d;
  logic             le_q, le_d;
  logic             te_q, te_d;
  logic             wrap;

  assign wrap = (cnt_q == div_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    k_d     = k_q;
    cpol_d  = cpol_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    fe_d    = 1'b0;
    le_d    = 1'b0;
    te_d    = 1'b0;
    case (state_q)
      IDLE: begin
        sclk_d = cpol;
        busy_d = 1'b0;
        cs_n_d = 1'b1;
        if (start) begin
          state_d = START;
          cpol_d  = cpol;
          div_d   = clk_div;
          cnt_d   = '0;
          k_d     = '0;
          fe_d    = 1'b1;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
        end
      end
      // START is the first counted cycle of the first half-period.
      START, RUN: begin
        state_d = RUN;
        cnt_d   = wrap ? '0 : cnt_q + 1'b1;
        if (wrap) begin
          sclk_d = ~sclk_q;
          k_d    = k_q + 1'b1;
          if (!k_q[0]) le_d = 1'b1;
          else         te_d = 1'b1;
          if (k_q == KW'(EDGES - 1)) state_d = HOLD;
        end
      end
      HOLD: begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        if (wrap) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cs_n_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      k_q     <= '0;
      cpol_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      fe_q    <= 1'b0;
      le_q    <= 1'b0;
      te_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      k_q     <= k_d;
      cpol_q  <= cpol_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      fe_q    <= fe_d;
      le_q    <= le_d;
      te_q    <= te_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign cs_n          = cs_n_q;
  assign sclk          = sclk_q;
  assign first_edge    = fe_q;
  assign leading_edge  = le_q;
  assign trailing_edge = te_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Directed bench for spi_sclk_gen: per-cycle output traces compared against
// frame timing computed from T, H and cpol.
module tb_spi_sclk_gen;
  localparam int DW = 8;

  logic       clk, rst, start, cpol;
  logic [7:0] clk_div;
  logic       busy, done, cs_n, sclk, first_edge, leading_edge, trailing_edge;

  spi_sclk_gen #(.DATA_W(DW), .DIV_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cpol(cpol), .clk_div(clk_div),
    .busy(busy), .done(done), .cs_n(cs_n), .sclk(sclk),
    .first_edge(first_edge), .leading_edge(leading_edge),
    .trailing_edge(trailing_edge)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] l_sclk, l_cs, l_busy, l_done, l_fe, l_le, l_te;
  logic [127:0] e_sclk, e_cs, e_busy, e_done, e_fe, e_le, e_te;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample(input int c);
    l_sclk[c] = sclk;
    l_cs[c]   = cs_n;
    l_busy[c] = busy;
    l_done[c] = done;
    l_fe[c]   = first_edge;
    l_le[c]   = leading_edge;
    l_te[c]   = trailing_edge;
  endtask

  task automatic drive(input int mode, input int c);
    case (mode)
      3: start = (c == 0) || (c == 10);
      4: start = 1'b1;
      5: begin
        start = (c == 0);
        rst   = (c == 9);
      end
      6: begin
        start = (c == 0);
        if (c == 8) begin
          clk_div = 8'd4;
          cpol    = 1'b1;
        end
      end
      default: start = (c == 0);
    endcase
  endtask

  // Entered and left #1 after a rising edge; index c is the cycle after edge c.
  task automatic run(input int mode, input int n);
    {l_sclk, l_cs, l_busy, l_done, l_fe, l_le, l_te} = '0;
    for (int c = 0; c <= n; c++) begin
      sample(c);
      drive(mode, c);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic exp_clear(input bit idle_sclk);
    e_sclk = idle_sclk ? '1 : '0;
    e_cs   = '1;
    {e_busy, e_done, e_fe, e_le, e_te} = '0;
  endtask

  // Frame started by start in cycle t with half-period h and polarity cp.
  task automatic add_frame(input int t, input int h, input bit cp);
    int last, e;
    last = t + 1 + (2 * DW + 1) * h;
    for (int c = t + 1; c <= last && c < 128; c++) begin
      e = (c - t - 1) / h;
      if (e > 2 * DW) e = 2 * DW;
      e_sclk[c] = cp ^ e[0];
      if (c < last) begin
        e_cs[c]   = 1'b0;
        e_busy[c] = 1'b1;
      end else begin
        e_done[c] = 1'b1;
      end
      if (c == t + 1) e_fe[c] = 1'b1;
      if (((c - t - 1) % h == 0) && e >= 1 && e <= 2 * DW && c < last) begin
        if (e[0]) e_le[c] = 1'b1;
        else      e_te[c] = 1'b1;
      end
    end
  endtask

  task automatic compare_all(input string tag, input int n);
    logic [127:0] m;
    m = (128'd1 << (n + 1)) - 128'd1;
    chk({tag, ".sclk"}, l_sclk & m, e_sclk & m);
    chk({tag, ".cs_n"}, l_cs & m, e_cs & m);
    chk({tag, ".busy"}, l_busy & m, e_busy & m);
    chk({tag, ".done"}, l_done & m, e_done & m);
    chk({tag, ".first"}, l_fe & m, e_fe & m);
    chk({tag, ".lead"}, l_le & m, e_le & m);
    chk({tag, ".trail"}, l_te & m, e_te & m);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cpol = 1'b1; clk_div = 8'd0;
    idle(3);
    chk("reset", 128'({busy, done, cs_n, sclk, first_edge, leading_edge, trailing_edge}),
        128'(7'b0010000));
    rst = 1'b0;

    // 1: nominal frame, cpol=0, H=2
    cpol = 1'b0; clk_div = 8'd1; idle(5);
    run(1, 40);
    exp_clear(1'b0); add_frame(0, 2, 1'b0);
    compare_all("t1", 40);
    chk("t1.nlead", 128'($countones(l_le)), 128'd8);
    chk("t1.ntrail", 128'($countones(l_te)), 128'd8);

    // 2: cpol=1, H=1
    cpol = 1'b1; clk_div = 8'd0; idle(5);
    run(2, 24);
    exp_clear(1'b1); add_frame(0, 1, 1'b1);
    compare_all("t2", 24);

    // 3: second start while busy is ignored
    cpol = 1'b0; clk_div = 8'd1; idle(5);
    run(3, 40);
    exp_clear(1'b0); add_frame(0, 2, 1'b0);
    compare_all("t3", 40);
    chk("t3.nedges", 128'($countones(l_le | l_te)), 128'd16);

    // 4: start held high, back-to-back frames
    idle(5);
    run(4, 70);
    exp_clear(1'b0); add_frame(0, 2, 1'b0); add_frame(35, 2, 1'b0);
    compare_all("t4", 70);
    idle(80);

    // 5: reset mid-frame, then a fresh frame
    cpol = 1'b1; clk_div = 8'd1; idle(5);
    run(5, 20);
    chk("t5.busy10", 128'(l_busy[10]), 128'd0);
    chk("t5.cs10", 128'(l_cs[10]), 128'd1);
    chk("t5.sclk10", 128'(l_sclk[10]), 128'd0);
    chk("t5.sclk11", 128'(l_sclk[11]), 128'd1);
    chk("t5.nodone", l_done & ((128'd1 << 21) - 128'd1), 128'd0);
    cpol = 1'b0; clk_div = 8'd0; idle(5);
    run(1, 24);
    exp_clear(1'b0); add_frame(0, 1, 1'b0);
    compare_all("t5b", 24);

    // 6: cpol/clk_div change mid-frame has no effect until idle
    cpol = 1'b0; clk_div = 8'd1; idle(5);
    run(6, 40);
    exp_clear(1'b0); add_frame(0, 2, 1'b0);
    for (int c = 36; c <= 40; c++) e_sclk[c] = 1'b1;
    compare_all("t6", 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
